alu4_nibble_seq: RTL and testbench

- Nibble-serial sequencer that sits directly upstream of the 4-bit ALU (alu4) and consumes its F/Cout on the same cycle.
- Accepts one wide command (NIBBLES x 4 bits) via valid/ready and presents the operands to the ALU one nibble per cycle, LSB nibble first.
- In arithmetic mode it chains Cout into the next nibble's Cin, collects the result into a wide register, and returns it via a second valid/ready handshake.
- This gives the team 8/16/32-bit operations built from the existing 4-bit ALU.

---
 rtl/alu4_nibble_seq.sv | 115 +++++++++++
 tb/tb_alu4_nibble_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu4_nibble_seq.sv
// Nibble-serial sequencer driving a combinational 4-bit ALU: one wide command in,
// one nibble per cycle LSB first with carry chaining, one wide result out.
module alu4_nibble_seq #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [4*NIBBLES-1:0]   cmd_a,
   input  logic [4*NIBBLES-1:0]   cmd_b,
   input  logic [1:0]             cmd_op,
   input  logic                   cmd_mode,
   input  logic                   cmd_cin,
   output logic [3:0]             alu_a,
   output logic [3:0]             alu_b,
   output logic                   alu_cin,
   output logic [1:0]             alu_op,
   output logic                   alu_mode,
   input  logic [3:0]             alu_f,
   input  logic                   alu_cout,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [4*NIBBLES-1:0]   res_f,
   output logic                   res_cout,
   output logic                   res_zero
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic [W-1:0]    a_reg, b_reg, res_f_reg;
   logic [1:0]      op_reg;
   logic            mode_reg;
   logic            carry;
   logic [IW-1:0]   idx;
   logic            res_cout_reg;
   logic            last;
   logic            accept;

   assign last   = (idx == IW'(NIBBLES - 1));
   assign accept = cmd_valid && cmd_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)    state_nxt = RUN;
         RUN:     if (last)      state_nxt = DONE;
         DONE:    if (res_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // ALU operands are only presented while a nibble is in flight; zero otherwise.
   always_comb begin
      alu_a    = 4'd0;
      alu_b    = 4'd0;
      alu_cin  = 1'b0;
      alu_op   = 2'd0;
      alu_mode = 1'b0;
      if (state == RUN) begin
         alu_a    = a_reg[{idx, 2'b00} +: 4];
         alu_b    = b_reg[{idx, 2'b00} +: 4];
         alu_cin  = carry;
         alu_op   = op_reg;
         alu_mode = mode_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         a_reg        <= '0;
         b_reg        <= '0;
         res_f_reg    <= '0;
         op_reg       <= '0;
         mode_reg     <= 1'b0;
         carry        <= 1'b0;
         idx          <= '0;
         res_cout_reg <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (accept) begin
                  a_reg    <= cmd_a;
                  b_reg    <= cmd_b;
                  op_reg   <= cmd_op;
                  mode_reg <= cmd_mode;
                  carry    <= cmd_cin & cmd_mode;
                  idx      <= '0;
               end
            end
            RUN: begin
               // Carry is masked by mode so logic ops never see the ALU's Cout.
               res_f_reg[{idx, 2'b00} +: 4] <= alu_f;
               carry <= alu_cout & mode_reg;
               idx   <= last ? '0 : idx + IW'(1);
               if (last) res_cout_reg <= alu_cout & mode_reg;
            end
            default: ;
         endcase
      end
   end

   assign cmd_ready = (state == IDLE) && !rst;
   assign res_valid = (state == DONE);
   assign res_f     = res_f_reg;
   assign res_cout  = res_cout_reg;
   assign res_zero  = (res_f_reg == '0);

endmodule

// File: tb/tb_alu4_nibble_seq.sv
// Bench for alu4_nibble_seq with a behavioural 4-bit ALU stub and a word-level reference model.
module tb_alu4_nibble_seq;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic          clk = 1'b0;
   logic          rst, cmd_valid, cmd_ready, cmd_mode, cmd_cin;
   logic [W-1:0]  cmd_a, cmd_b, res_f;
   logic [1:0]    cmd_op, alu_op;
   logic [3:0]    alu_a, alu_b, alu_f;
   logic          alu_cin, alu_mode, alu_cout;
   logic          res_valid, res_ready, res_cout, res_zero;

   int tests = 0;
   int fails = 0;

   alu4_nibble_seq #(.NIBBLES(N)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_cin(cmd_cin),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op), .alu_mode(alu_mode),
      .alu_f(alu_f), .alu_cout(alu_cout),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_f(res_f), .res_cout(res_cout), .res_zero(res_zero)
   );

   always #5 clk = ~clk;

   // ALU stub; in logic mode Cout is forced high so any leak into the carry chain shows up.
   always_comb begin
      alu_f    = 4'd0;
      alu_cout = 1'b1;
      if (alu_mode) begin
         {alu_cout, alu_f} = {1'b0, alu_a} + {1'b0, alu_b} + 5'(alu_cin);
      end else begin
         case (alu_op)
            2'b00: alu_f = alu_a & alu_b;
            2'b01: alu_f = alu_a | alu_b;
            2'b10: alu_f = alu_a ^ alu_b;
            default: alu_f = ~alu_a;
         endcase
      end
   end

   typedef struct {
      logic [W-1:0] a, b;
      logic [1:0]   op;
      logic         m, c;
      logic [W-1:0] f;
      logic         co, z;
      logic [N-1:0] cs;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Word-level reference: whole-operand arithmetic or bitwise op, plus the carry seen entering each nibble.
   task automatic ref_model(input logic [W-1:0] a, b, input logic [1:0] op, input logic m, c,
                            output logic [W-1:0] f, output logic co, z, output logic [N-1:0] cs);
      logic [W:0]   sum;
      logic [W:0]   part;
      logic [W-1:0] mask;
      cs = '0;
      if (m) begin
         sum = {1'b0, a} + {1'b0, b} + (W+1)'(c);
         f   = sum[W-1:0];
         co  = sum[W];
         cs[0] = c;
         for (int k = 1; k < N; k++) begin
            mask  = (W'(1) << (4*k)) - W'(1);
            part  = {1'b0, a & mask} + {1'b0, b & mask} + (W+1)'(c);
            cs[k] = part[4*k];
         end
      end else begin
         co = 1'b0;
         case (op)
            2'b00: f = a & b;
            2'b01: f = a | b;
            2'b10: f = a ^ b;
            default: f = ~a;
         endcase
      end
      z = (f == '0);
   endtask

   // Runs one command from an IDLE negedge; leaves the bench at the IDLE negedge after the result handshake.
   task automatic do_cmd(input vec_t v, input int hold, input bit pend);
      int w;
      logic [N-1:0] cs_got;
      logic [W-1:0] f_got;
      cmd_a = v.a; cmd_b = v.b; cmd_op = v.op; cmd_mode = v.m; cmd_cin = v.c;
      cmd_valid = 1'b1;
      w = 0;
      while (!cmd_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (w >= 50) chk("accept_timeout", 32'(w), 32'd0);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         chk($sformatf("alu_a[%0d]", k), 32'(alu_a), 32'(v.a[4*k +: 4]));
         chk($sformatf("alu_b[%0d]", k), 32'(alu_b), 32'(v.b[4*k +: 4]));
         chk("early_res_valid", 32'(res_valid), 32'd0);
         chk("run_cmd_ready", 32'(cmd_ready), 32'd0);
         cs_got[k] = alu_cin;
         @(negedge clk);
      end
      chk("cin_seq", 32'(cs_got), 32'(v.cs));
      chk("res_valid_latency", 32'(res_valid), 32'd1);
      chk("res_f", 32'(res_f), 32'(v.f));
      chk("res_cout", 32'(res_cout), 32'(v.co));
      chk("res_zero", 32'(res_zero), 32'(v.z));
      f_got = res_f;
      if (pend) cmd_valid = 1'b1;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_res_f", 32'(res_f), 32'(f_got));
         chk("hold_res_valid", 32'(res_valid), 32'd1);
         chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
         chk("hold_alu_a_idle", 32'(alu_a), 32'd0);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("post_hs_res_valid", 32'(res_valid), 32'd0);
      chk("post_hs_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("post_hs_res_f_kept", 32'(res_f), 32'(f_got));
   endtask

   vec_t tbl[6];
   vec_t v;

   initial begin
      tbl[0] = '{16'h1234, 16'h0FFF, 2'b00, 1'b1, 1'b0, 16'h2233, 1'b0, 1'b0, 4'b1110};
      tbl[1] = '{16'hFFFF, 16'h0001, 2'b00, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b1110};
      tbl[2] = '{16'h5A5A, 16'h0FF0, 2'b00, 1'b0, 1'b1, 16'h0A50, 1'b0, 1'b0, 4'b0000};
      tbl[3] = '{16'h8000, 16'h8000, 2'b00, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 4'b0001};
      tbl[4] = '{16'hF0F0, 16'h0F0F, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'b0000};
      tbl[5] = '{16'h1234, 16'h1234, 2'b10, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 4'b0000};

      rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
      cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_mode = 1'b0; cmd_cin = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_res_valid", 32'(res_valid), 32'd0);
      chk("idle_alu_a", 32'(alu_a), 32'd0);
      chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("idle_res_f", 32'(res_f), 32'd0);

      for (int i = 0; i < 6; i++) do_cmd(tbl[i], 0, 1'b0);

      // Backpressure with a waiting command; it must start only after the handshake.
      do_cmd(tbl[0], 6, 1'b1);
      do_cmd(tbl[3], 0, 1'b0);

      // Abort mid-operation at idx=2.
      cmd_a = 16'hFFFF; cmd_b = 16'hFFFF; cmd_op = 2'b00; cmd_mode = 1'b1; cmd_cin = 1'b1;
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_idx2_alu_a", 32'(alu_a), 32'hF);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_rst_cmd_ready", 32'(cmd_ready), 32'd0);
      rst = 1'b0;
      chk("abort_res_f_cleared", 32'(res_f), 32'd0);
      begin
         int seen = 0;
         for (int k = 0; k < 8; k++) begin
            if (res_valid) seen++;
            @(negedge clk);
         end
         chk("abort_no_res_valid", 32'(seen), 32'd0);
      end
      v = '{16'h0001, 16'h0001, 2'b00, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0, 4'b0000};
      do_cmd(v, 0, 1'b0);

      for (int i = 0; i < 20; i++) begin
         v.a  = W'($urandom);
         v.b  = W'($urandom);
         v.op = 2'($urandom_range(3));
         v.m  = 1'($urandom_range(1));
         v.c  = 1'($urandom_range(1));
         if (i == 0) v.b = ~v.a;
         ref_model(v.a, v.b, v.op, v.m, v.c, v.f, v.co, v.z, v.cs);
         do_cmd(v, int'($urandom_range(3)), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
      $fatal(1);
   end

endmodule
